dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// - Shares one single-ported synchronous data memory between two masters:
//   port 0 is the CPU load/store port, port 1 is the DMA/debug loader port.
// - Arbitrates per cycle with round-robin between the two ports.
// - Port 1 can lock the memory for a bounded burst.
// - Drives the memory port and routes the 1-cycle-latency read data back to
//   whichever port issued the read.
// - The CPU stalls (clock-enable low) whenever m0_req=1 and m0_ready=0.
// PARAMETERS
// - ADDR_W    32  address width, all ports
// - DATA_W    32  data width, all ports
// - MAX_LOCK  8   maximum consecutive port-1 grants while m1_lock=1 (>=1)
// PORTS
// - clk        in   1       clock; all state updates on the rising edge
// - reset      in   1       asynchronous, active-low reset
// - m0_req     in   1       port 0 request valid
// - m0_we      in   1       port 0 write (1) / read (0)
// - m0_addr    in   ADDR_W  port 0 address
// - m0_wdata   in   DATA_W  port 0 write data
// - m0_ready   out  1       port 0 accepted this cycle (combinational)
// - m0_rvalid  out  1       port 0 read data valid (registered)
// - m0_rdata   out  DATA_W  port 0 read data
// - m1_req, m1_we, m1_addr, m1_wdata, m1_ready, m1_rvalid, m1_rdata
//   same as port 0, for port 1
// - m1_lock    in   1       port 1 requests exclusive back-to-back grants
// - mem_en     out  1       memory access strobe
// - mem_we     out  1       memory write enable
// - mem_addr   out  ADDR_W  memory address
// - mem_wdata  out  DATA_W  memory write data
// - mem_rdata  in   DATA_W  memory read data, valid 1 cycle after a read
// BEHAVIOUR
// - Handshake: a transfer occurs in cycle t when mX_req && mX_ready.
//   - The memory is driven in the same cycle t.
//   - At most one port is ready per cycle.
//   - Requesters hold req, we, addr and wdata stable until ready.
// - Memory drive:
//   - mem_en = m0_ready | m1_ready.
//   - mem_we, mem_addr and mem_wdata are muxed from the granted port.
//   - When no port is granted, all memory outputs are 0.
// - Read return:
//   - A read accepted at t gives mX_rvalid=1 at t+1, for one cycle only.
//   - rd_owner is registered at t; mX_rdata = mem_rdata when rd_owner==X,
//     otherwise 0.
//   - A write never produces rvalid.
// - State last_gnt (1 bit): the port granted most recently. It updates on
//   every transfer.
// - FSM states are ARB and LOCK.
//   - ARB, single requester: the requester is granted.
//   - ARB, both requesting: the port != last_gnt is granted.
//   - ARB -> LOCK on an m1 transfer with m1_lock=1; lock_cnt <= 1.
//   - LOCK: m0_ready=0. m1_ready = m1_req.
//     - lock_cnt increments on each m1 transfer and saturates at MAX_LOCK.
//   - LOCK -> ARB in the cycle after m1_lock is sampled 0.
//     - m1_lock=0 in LOCK makes that cycle arbitrate as ARB.
//   - LOCK -> ARB when lock_cnt==MAX_LOCK and a transfer completes.
//     - This sets force0=1.
//   - force0=1: m0 wins the next cycle in which m0_req=1.
//     - force0 clears on the m0 grant.
//     - m1 may still be granted while m0_req=0.
//   - An idle m1 in LOCK (m1_req=0, m1_lock=1) holds the lock but does not
//     count; the MAX_LOCK budget counts grants only.
// - Reset (reset=0, asynchronous):
//   - state=ARB, last_gnt=1 (m0 wins the first contention), lock_cnt=0,
//     force0=0, rd_owner=0.
//   - m0_rvalid=m1_rvalid=0.
//   - m0_ready, m1_ready and mem_en are forced 0 while reset=0.
//   - A read in flight when reset asserts is dropped: no rvalid after release.
// - A write then read of the same address on consecutive cycles returns the
//   new data; the memory has write-first-cycle ordering, so no forwarding
//   here.
// - Throughput: one transfer per cycle. There are no bubbles between
//   grants, including port switches.
// TESTING
// - Reset release, m0 read @0x10 (mem holds 0xDEADBEEF)
//   -> m0_ready=1 at t, m0_rvalid=1 with m0_rdata=0xDEADBEEF at t+1.
// - Both ports request continuously
//   -> grants alternate m0,m1,m0,m1 starting with m0.
//   -> No cycle has both ready; no idle cycle.
// - m1_lock=1 with m1 streaming 10 writes, m0_req=1 throughout, MAX_LOCK=8
//   -> 8 m1 grants, then m0 granted, then m1 resumes.
// - m1 locks, idles 5 cycles with m1_lock=1, then drops lock
//   -> m0 stalled for those cycles, granted the cycle after m1_lock=0 is
//      sampled.
// - Back-to-back m0 write 0x55 @0x20, then m1 read @0x20
//   -> m1_rdata=0x55; m0_rvalid stays 0.
// - reset pulsed low mid-read (async, between edges)
//   -> rvalid=0 and ready=0 immediately.
//   -> After release, arbitration restarts with m0 priority.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter with port-1 burst lock for a single-ported data memory
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   m0_*                  CPU load/store port (req/we/addr/wdata in, ready/rvalid/rdata out)
//   m1_*                  DMA/debug loader port, same as m0 plus m1_lock
//   mem_en/we/addr/wdata  memory drive, zero when nothing is granted
//   mem_rdata             memory read data, one cycle after a read strobe
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              m1_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic {ARB, LOCK} arbState_t;

    arbState_t        state;
    logic             lastGnt;
    logic             force0;
    logic             rdOwner;
    logic [CNT_W-1:0] lockCnt;
    logic             gnt0;
    logic             gnt1;
    logic             lockHeld;

    // A LOCK cycle with m1_lock low is arbitrated exactly like ARB.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        lockHeld = (state == LOCK) && m1_lock;
        if (!reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (lockHeld) begin
            gnt1 = m1_req;
        end else if (force0 && m0_req) begin
            gnt0 = 1'b1;
        end else if (m0_req && m1_req) begin
            gnt0 = lastGnt;
            gnt1 = !lastGnt;
        end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
        end
    end

    assign m0_ready  = gnt0;
    assign m1_ready  = gnt1;
    assign mem_en    = gnt0 | gnt1;
    assign mem_we    = gnt0 ? m0_we    : (gnt1 ? m1_we    : 1'b0);
    assign mem_addr  = gnt0 ? m0_addr  : (gnt1 ? m1_addr  : '0);
    assign mem_wdata = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : '0);

    assign m0_rdata = (rdOwner == 1'b0) ? mem_rdata : '0;
    assign m1_rdata = (rdOwner == 1'b1) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB;
            lastGnt   <= 1'b1;
            force0    <= 1'b0;
            rdOwner   <= 1'b0;
            lockCnt   <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= gnt0 && !m0_we;
            m1_rvalid <= gnt1 && !m1_we;
            if (gnt0 && !m0_we) begin
                rdOwner <= 1'b0;
            end else if (gnt1 && !m1_we) begin
                rdOwner <= 1'b1;
            end
            if (gnt0 || gnt1) begin
                lastGnt <= gnt1;
            end
            if (gnt0) begin
                force0 <= 1'b0;
            end

            case (state)
                ARB: begin
                    // A pending force0 means m0 is owed a slot; m1 gets plain
                    // grants until then instead of starting a new lock.
                    if (gnt1 && m1_lock && !force0) begin
                        lockCnt <= CNT_W'(1);
                        if (MAX_LOCK == 1) begin
                            force0 <= 1'b1;
                        end else begin
                            state <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    if (!m1_lock) begin
                        state   <= ARB;
                        lockCnt <= '0;
                    end else if (gnt1) begin
                        // The grant that reaches the budget ends the burst.
                        if (lockCnt >= CNT_W'(MAX_LOCK - 1)) begin
                            lockCnt <= CNT_W'(MAX_LOCK);
                            state   <= ARB;
                            force0  <= 1'b1;
                        end else begin
                            lockCnt <= lockCnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_ready, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m1_ready, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        m1_lock = 1'b0;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic        initMem = 1'b1;
    logic [31:0] memArr [256];
    logic [31:0] refMem [256];

    op_t         ops0[$];
    op_t         ops1[$];
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          gntLog[$];
    int          expLog[$];
    int          nChecks = 0;
    int          nFails = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_lock(m1_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initVal(int a);
        return (a == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
    endfunction

    // Single-ported synchronous memory, one-cycle read latency.
    always @(posedge clk) begin
        if (initMem) begin
            for (int i = 0; i < 256; i++) memArr[i] <= initVal(i);
        end else if (mem_en) begin
            if (mem_we) memArr[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= memArr[mem_addr[7:0]];
        end
    end

    task automatic checkVal(string tag, logic [63:0] got, logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkRead();
        if (m0_rvalid || exp0.size() != 0) begin
            checkVal("m0_rvalid", m0_rvalid, exp0.size() != 0);
            if (exp0.size() != 0) begin
                logic [31:0] e = exp0.pop_front();
                if (m0_rvalid) checkVal("m0_rdata", m0_rdata, e);
            end
        end
        if (m1_rvalid || exp1.size() != 0) begin
            checkVal("m1_rvalid", m1_rvalid, exp1.size() != 0);
            if (exp1.size() != 0) begin
                logic [31:0] e = exp1.pop_front();
                if (m1_rvalid) checkVal("m1_rdata", m1_rdata, e);
            end
        end
    endtask

    // Called at posedge+1: presents queue heads, samples grants, scoreboards.
    task automatic runCycle();
        m0_req = ops0.size() != 0;
        m1_req = ops1.size() != 0;
        {m0_we, m0_addr, m0_wdata} = m0_req ? {ops0[0].we, ops0[0].addr, ops0[0].data} : 65'd0;
        {m1_we, m1_addr, m1_wdata} = m1_req ? {ops1[0].we, ops1[0].addr, ops1[0].data} : 65'd0;
        #2;
        checkVal("single ready", m0_ready & m1_ready, 1'b0);
        if (m0_req && m0_ready) begin
            gntLog.push_back(0);
            if (m0_we) refMem[m0_addr[7:0]] = m0_wdata;
            else       exp0.push_back(refMem[m0_addr[7:0]]);
            void'(ops0.pop_front());
        end else if (m1_req && m1_ready) begin
            gntLog.push_back(1);
            if (m1_we) refMem[m1_addr[7:0]] = m1_wdata;
            else       exp1.push_back(refMem[m1_addr[7:0]]);
            void'(ops1.pop_front());
        end else begin
            gntLog.push_back(2);
        end
        @(posedge clk);
        #1;
        checkRead();
    endtask

    task automatic checkLog(string tag, input int e[$]);
        checkVal({tag, " length"}, gntLog.size(), e.size());
        for (int i = 0; i < e.size() && i < gntLog.size(); i++)
            checkVal($sformatf("%s grant[%0d]", tag, i), gntLog[i], e[i]);
        gntLog.delete();
    endtask

    task automatic doReset();
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        ops0.delete(); ops1.delete(); exp0.delete(); exp1.delete(); gntLog.delete();
    endtask

    task automatic drain(string tag);
        int n = 0;
        while ((ops0.size() != 0 || ops1.size() != 0) && n < 40) begin
            m1_lock = m1_lock && (ops1.size() != 0);
            runCycle();
            n++;
        end
        checkVal({tag, " completed"}, n < 40, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = initVal(i);
        #1 reset = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h10;
        @(posedge clk);
        #1;
        initMem = 1'b0;
        checkVal("reset m0_ready", m0_ready, 1'b0);
        checkVal("reset m1_ready", m1_ready, 1'b0);
        checkVal("reset mem_en", mem_en, 1'b0);
        checkVal("reset m0_rvalid", m0_rvalid, 1'b0);
        checkVal("reset m1_rvalid", m1_rvalid, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // First read after reset.
        ops0.push_back('{1'b0, 32'h10, 32'h0});
        runCycle();
        expLog = '{0};
        checkLog("first read", expLog);

        // Both ports streaming reads: strict alternation from m0.
        doReset();
        for (int i = 0; i < 6; i++) begin
            ops0.push_back('{1'b0, 32'(8'h80 + i), 32'h0});
            ops1.push_back('{1'b0, 32'(8'h90 + i), 32'h0});
        end
        drain("round robin");
        expLog = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        checkLog("round robin", expLog);

        // Locked burst of 10 writes against a persistent m0 requester.
        doReset();
        for (int i = 0; i < 4; i++) ops0.push_back('{1'b0, 32'(8'h30 + i), 32'h0});
        for (int i = 0; i < 10; i++) ops1.push_back('{1'b1, 32'(8'h40 + i), 32'hA000 + 32'(i)});
        m1_lock = 1'b1;
        drain("lock budget");
        expLog = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        checkLog("lock budget", expLog);

        // Idle lock holder stalls m0 until the lock drops.
        doReset();
        ops1.push_back('{1'b1, 32'h60, 32'h1234});
        m1_lock = 1'b1;
        runCycle();
        ops0.push_back('{1'b0, 32'h11, 32'h0});
        for (int i = 0; i < 5; i++) runCycle();
        m1_lock = 1'b0;
        runCycle();
        expLog = '{1, 2, 2, 2, 2, 2, 0};
        checkLog("idle lock", expLog);

        // m0 write then m1 read of the same address.
        doReset();
        ops0.push_back('{1'b1, 32'h20, 32'h55});
        ops1.push_back('{1'b0, 32'h20, 32'h0});
        drain("write then read");
        expLog = '{0, 1};
        checkLog("write then read", expLog);
        checkVal("refMem 0x20", refMem[8'h20], 32'h55);

        // Asynchronous reset while read data is on the bus.
        doReset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        #2;
        checkVal("mid-read accept", m0_ready, 1'b1);
        @(posedge clk);
        #1;
        checkVal("mid-read rvalid", m0_rvalid, 1'b1);
        checkVal("mid-read rdata", m0_rdata, 32'hDEADBEEF);
        reset = 1'b0;
        #1;
        checkVal("async m0_rvalid", m0_rvalid, 1'b0);
        checkVal("async m0_ready", m0_ready, 1'b0);
        checkVal("async mem_en", mem_en, 1'b0);
        m0_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkVal("post-reset m0_rvalid", m0_rvalid, 1'b0);
        checkVal("post-reset m1_rvalid", m1_rvalid, 1'b0);
        for (int i = 0; i < 2; i++) begin
            ops0.push_back('{1'b0, 32'(8'hA0 + i), 32'h0});
            ops1.push_back('{1'b0, 32'(8'hB0 + i), 32'h0});
        end
        drain("after async reset");
        expLog = '{0, 1, 0, 1};
        checkLog("after async reset", expLog);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
